// File: rtl/gnt_arbiter_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
//   state_e         : arbiter FSM states
//   N_DEFAULT       : default requester count
//   MAX_HOLD_DEFAULT: default hold limit (timeout build only)
//   hcnt_width()    : width of the hold counter for a given MAX_HOLD
package gnt_arbiter_pkg;

    localparam int unsigned N_DEFAULT        = 4;
    localparam int unsigned MAX_HOLD_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    // Hold counter must be able to represent MAX_HOLD itself.
    function automatic int unsigned hcnt_width(input int unsigned max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/gnt_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index of the previous winner; search starts at ptr+1 and wraps
//   win   : index of the first requester found
//   valid : at least one request is set
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] win,
    output logic          valid
);

    int unsigned idx;

    // First set bit at or after ptr+1, modulo N.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!valid && req[PW'(idx)]) begin
                valid = 1'b1;
                win   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/gnt_arbiter.sv
// Round-robin request/grant arbiter with one-hot grant and new-grant pulse.
// Optional hold timeout enabled by defining GNT_ARBITER_TIMEOUT_EN.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   req   : per-requester request level
//   gnt   : one-hot or zero grant, registered owner masked by live req
//   en    : registered one-cycle pulse on the first cycle of each grant
//   ok    : registered health flag, low for one cycle after a timeout revoke
module gnt_arbiter
    import gnt_arbiter_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         en,
    output logic         ok
);

    localparam int unsigned PW = $clog2(N);

    if (N < 2 || N > 16 || MAX_HOLD < 2) begin : g_param_check
        $error("gnt_arbiter: N must be 2..16 and MAX_HOLD at least 2");
    end

    state_e        state_q, state_d;
    logic [PW-1:0] own_q, own_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          en_d, ok_d;
    logic          load;
    logic          timeout;
    logic [PW-1:0] win;
    logic          win_vld;

    // Single picker shared by IDLE and COOLDOWN.
    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .valid (win_vld)
    );

`ifdef GNT_ARBITER_TIMEOUT_EN
    localparam int unsigned HW = hcnt_width(MAX_HOLD);

    logic [HW-1:0] hcnt_q, hcnt_d;

    assign timeout = (hcnt_q == HW'(MAX_HOLD));

    // Hold counter: 1 on a new grant, saturating count while held.
    always_comb begin
        hcnt_d = hcnt_q;
        if (load) begin
            hcnt_d = HW'(1);
        end else if (state_q == ST_GRANT && !timeout) begin
            hcnt_d = hcnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            own_q   <= '0;
            ptr_q   <= PW'(N - 1);
            en      <= 1'b0;
            ok      <= 1'b1;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            en      <= en_d;
            ok      <= ok_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        en_d    = 1'b0;
        ok_d    = 1'b1;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_COOLDOWN: begin
                state_d = ST_IDLE;
                if (win_vld) begin
                    state_d = ST_GRANT;
                    own_d   = win;
                    ptr_d   = win;
                    en_d    = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!req[own_q]) begin
                    state_d = ST_COOLDOWN;
                end else if (timeout) begin
                    state_d = ST_COOLDOWN;
                    ok_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Live req mask drops the grant in the same cycle the owner releases.
    assign gnt = (state_q == ST_GRANT) ? ((N'(1) << own_q) & req) : '0;

endmodule

// File: tb/tb_gnt_arbiter.sv
module tb_gnt_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;
`ifdef GNT_ARBITER_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         en;
    logic         ok;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference model: who holds the resource, last winner, cycles held.
    bit m_busy;
    int m_own;
    int m_last;
    int m_held;
    bit m_en;
    bit m_ok;

    gnt_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .en    (en),
        .ok    (ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (last + k) % int'(N);
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt(input logic [N-1:0] r);
        logic [N-1:0] g;
        g = '0;
        if (m_busy && r[m_own]) g[m_own] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_own  = 0;
        m_last = int'(N) - 1;
        m_held = 0;
        m_en   = 1'b0;
        m_ok   = 1'b1;
    endtask

    // Advance the model by one clock edge that samples r.
    task automatic model_step(input logic [N-1:0] r);
        int w;
        m_en = 1'b0;
        m_ok = 1'b1;
        if (m_busy) begin
            if (!r[m_own]) begin
                m_busy = 1'b0;
            end else if (TIMEOUT && m_held >= int'(MAX_HOLD)) begin
                m_busy = 1'b0;
                m_ok   = 1'b0;
            end else begin
                m_held++;
            end
        end else begin
            w = pick(r, m_last);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_own  = w;
                m_last = w;
                m_held = 1;
                m_en   = 1'b1;
            end
        end
    endtask

    // Drive r at negedge, check the combinational grant, then let one edge pass.
    task automatic step(input logic [N-1:0] r);
        @(negedge clk);
        req = r;
        #1;
        chk("gnt_comb", 32'(gnt), 32'(exp_gnt(r)));
        model_step(r);
        @(posedge clk);
        #4;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_ok", 32'(ok), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison against the model, after each edge settles.
    always @(posedge clk) begin
        #3;
        if (chk_on) begin
            chk("gnt", 32'(gnt), 32'(exp_gnt(req)));
            chk("en", 32'(en), 32'(m_en));
            chk("ok", 32'(ok), 32'(m_ok));
        end
    end

    logic [N-1:0] seq_g [5];
    logic [N-1:0] r;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_en", 32'(en), 32'h0);
        chk("reset_ok", 32'(ok), 32'h1);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // First grant latency.
        step(4'b0000);
        step(4'b0000);
        step(4'b0001);
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_en", 32'(en), 32'h1);
        chk("first_ok", 32'(ok), 32'h1);
        step(4'b0001);
        chk("first_en_drop", 32'(en), 32'h0);
        chk("first_gnt_hold", 32'(gnt), 32'h1);

        // Rotation with all requesting, each owner releasing after 2 cycles.
        reset_pulse();
        seq_g[0] = 4'b0001; seq_g[1] = 4'b0010; seq_g[2] = 4'b0100;
        seq_g[3] = 4'b1000; seq_g[4] = 4'b0001;
        step(4'b1111);
        for (int i = 0; i < 5; i++) begin
            chk("rr_gnt", 32'(gnt), 32'(seq_g[i]));
            chk("rr_en", 32'(en), 32'h1);
            step(4'b1111);
            step(4'b1111 & ~seq_g[i]);
            chk("rr_cooldown", 32'(gnt), 32'h0);
            step(4'b1111);
        end

        // Owner 2 releases; next grant no earlier than two edges later.
        reset_pulse();
        step(4'b0100);
        chk("rel_gnt", 32'(gnt), 32'h4);
        step(4'b0110);
        chk("rel_nonowner", 32'(gnt), 32'h4);
        step(4'b0010);
        chk("rel_cool", 32'(gnt), 32'h0);
        step(4'b0010);
        chk("rel_next", 32'(gnt), 32'h2);
        chk("rel_next_en", 32'(en), 32'h1);

        // Long hold: revoked after MAX_HOLD with timeout, held forever otherwise.
        reset_pulse();
        step(4'b0010);
        chk("hold_gnt", 32'(gnt), 32'h2);
        for (int i = 1; i < int'(MAX_HOLD); i++) begin
            step(4'b0010);
            chk("hold_mid", 32'(gnt), 32'h2);
        end
        step(4'b0010);
`ifdef GNT_ARBITER_TIMEOUT_EN
        chk("to_revoke_gnt", 32'(gnt), 32'h0);
        chk("to_revoke_ok", 32'(ok), 32'h0);
        step(4'b0010);
        chk("to_regrant", 32'(gnt), 32'h2);
        chk("to_regrant_en", 32'(en), 32'h1);
        chk("to_regrant_ok", 32'(ok), 32'h1);

        reset_pulse();
        step(4'b0011);
        chk("to2_own0", 32'(gnt), 32'h1);
        repeat (MAX_HOLD - 1) step(4'b0011);
        step(4'b0011);
        chk("to2_revoke_ok", 32'(ok), 32'h0);
        step(4'b0011);
        chk("to2_own1", 32'(gnt), 32'h2);
        repeat (MAX_HOLD) step(4'b0011);
        step(4'b0011);
        chk("to2_own0_again", 32'(gnt), 32'h1);
`else
        chk("nto_held_gnt", 32'(gnt), 32'h2);
        chk("nto_held_ok", 32'(ok), 32'h1);
        repeat (4) step(4'b0010);
        chk("nto_long_gnt", 32'(gnt), 32'h2);
        chk("nto_long_en", 32'(en), 32'h0);
`endif

        // Reset during a grant, then a single requester.
        reset_pulse();
        step(4'b0100);
        step(4'b0100);
        chk("mid_pre", 32'(gnt), 32'h4);
        reset_pulse();
        step(4'b1000);
        chk("post_rst_gnt", 32'(gnt), 32'h8);
        chk("post_rst_en", 32'(en), 32'h1);

        // Randomized traffic with sticky request bits and rare resets.
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < int'(N); b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(299) == 0) begin
                reset_pulse();
            end
            step(r);
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnt_arbiter.md
# gnt_arbiter

Round-robin request/grant arbiter that produces the `gnt`, `en` and `ok` signals consumed by the downstream request/grant checker stage. It sits between N requesters and a shared resource. It issues at most one one-hot grant at a time and pulses `en` on each new grant. An optional hold-timeout revokes over-long grants and flags them by dropping `ok`. By construction, no grant is ever visible without its matching request.

## Interface
- `N`, default 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner. Used only with the timeout build; legal range ≥2.
- `clk`, input, 1: sole clock; all state changes on posedge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, N: per-requester request level, sampled at posedge.
- `gnt`, output, N: one-hot or zero grant. Equals registered owner vector AND `req`.
- `en`, output, 1: registered one-cycle pulse on the first cycle of each new grant.
- `ok`, output, 1: registered health flag. Low only in the cycle following a timeout revoke.

## Operation
- States: IDLE, GRANT, COOLDOWN. Held in a registered state variable plus owner index `own`, round-robin pointer `ptr`, and hold counter `hcnt`.
- Pick: search `req` starting at `(ptr+1) mod N`, wrapping; the first set bit wins. `ptr` updates to the winner on every grant.
- IDLE:
  - any `req` set → GRANT with the winner as owner, `en`=1 next cycle, `hcnt`=1.
  - else stay in IDLE.
- GRANT:
  - `req[own]` low → COOLDOWN.
  - timeout (`hcnt`==MAX_HOLD and `req[own]` high) → COOLDOWN, `ok`=0 next cycle.
  - else stay in GRANT; `hcnt` increments, saturating at MAX_HOLD.
- COOLDOWN: exactly one cycle with no grant. Arbitrates like IDLE: any `req` → GRANT, else → IDLE.
- `gnt` = `(1<<own & {N{state==GRANT}}) & req`. When the owner drops `req`, `gnt` falls in the same cycle, so `gnt && !req` is never true on any bit.
- A revoked owner that still requests competes normally. `ptr` has moved past it, so other requesters win first; if it is the sole requester, it is re-granted after COOLDOWN.
- Simultaneous requests: the pick order alone decides the winner; `req` changes on non-owners never disturb an active grant.
- Reset (asynchronous, any time, including mid-grant) forces all registers to their reset values immediately:
  - `gnt`=0, `en`=0, `ok`=1
  - state IDLE, `ptr`=N-1 (so requester 0 wins first), `own`=0, `hcnt`=0

## Timing
- Grant latency: `req` seen at edge k in IDLE/COOLDOWN → `gnt`, `en` high after edge k (cycle k+1).
- `en` is high for exactly one cycle per grant, never in consecutive cycles.
- Release: `req[own]` deasserted → `gnt` low combinationally. COOLDOWN occupies the next cycle, so the earliest new grant appears two cycles after the deassert edge.
- Timeout: owner granted at cycle g and holding → COOLDOWN at cycle g+MAX_HOLD with `ok`=0. `ok` returns to 1 at g+MAX_HOLD+1.
- `ok` never low for two consecutive cycles; `en` and low `ok` never coincide.

## Configuration
- `GNT_ARBITER_TIMEOUT_EN` defined: `hcnt` logic, `MAX_HOLD` revoke and `ok` deassertion are present as described.
- `GNT_ARBITER_TIMEOUT_EN` undefined: no `hcnt` is built and `MAX_HOLD` is ignored. A grant is held until `req[own]` drops, and `ok` is tied to 1.

## Structure
- Package `gnt_arbiter_pkg` holds:
  - the state enum (IDLE, GRANT, COOLDOWN)
  - the default `N`/`MAX_HOLD` constants
  - a function computing the `hcnt` width as `$clog2(MAX_HOLD+1)`
- Sub-module `rr_pick`: combinational; inputs are `req` and `ptr`, outputs are winner index and valid. Instanced once, shared by IDLE and COOLDOWN.

## Test plan
- Reset then `req`=4'b0001 at cycle 2 → `gnt`=0001 and `en`=1 at cycle 3; `en`=0 at cycle 4; `ok`=1 throughout.
- `req`=4'b1111 held, each owner releasing after 2 cycles → grants in order 0001, 0010, 0100, 1000, 0001, with one zero-grant COOLDOWN cycle between each.
- Owner 2 granted, drops `req[2]` mid-cycle → `gnt` becomes 0000 the same cycle; the next grant is no earlier than two edges later.
- Timeout build, MAX_HOLD=8, `req`=0010 held → `gnt` high for 8 cycles, then 1 cycle with `gnt`=0 and `ok`=0, then re-granted with `en`=1 and `ok`=1.
- Timeout build, `req`=0011 held → owner 0 revoked after 8 cycles; owner 1 granted after COOLDOWN; then owner 0 again.
- `rst_n` low during GRANT → `gnt`, `en` go 0 asynchronously and `ok`=1; after release, `req`=1000 yields 1000 with 1-cycle latency.
